reg_file_ser_master: RTL



---
 rtl/reg_file_ser_master_if.sv | 30 +++
 rtl/reg_file_ser_master.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/reg_file_ser_master_if.sv
// Request/response handshake and serial-line bundle for the register-file
// serialiser. "master" is the serialiser side, "slave" is the peer that
// issues requests and returns DOUT.
interface reg_file_ser_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WRITE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  BUSY;
  logic                  WR_EN;
  logic                  RD_EN;
  logic                  DIN;
  logic                  DOUT;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, DOUT,
    output REQ_READY, RSP_VALID, RSP_RDATA, BUSY, WR_EN, RD_EN, DIN
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, DOUT,
    input  REQ_READY, RSP_VALID, RSP_RDATA, BUSY, WR_EN, RD_EN, DIN
  );
endinterface

// File: rtl/reg_file_ser_master.sv
// Register-file serialiser: accepts one parallel request, emits a start
// strobe, shifts address (and write data) MSB-first onto DIN, collects the
// read word from DOUT and returns a one-cycle response.
module reg_file_ser_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_TURN    = 1,
  parameter int GAP        = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  reg_file_ser_master_if.master bus
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = ($clog2(MAXW + 1) > 4) ? $clog2(MAXW + 1) : 4;
  localparam int FW   = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STRB  = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;

  // Last counter value in each multi-cycle state.
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] T_LAST = CW'((RD_TURN > 0) ? RD_TURN - 1 : 0);
  localparam logic [CW-1:0] G_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         frame_q, frame_d;   // {addr, wdata}, shifted out MSB-first
  logic [DATA_WIDTH-1:0] rsh_q, rsh_d;       // DOUT collector
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;   // response word, held between DONEs
  logic                  wr_q, wr_d;
  logic                  init_q;             // keeps READY low until first edge after reset
  logic                  ready;

  assign ready = init_q && (state_q == S_IDLE);

  // Next-state and datapath: counter restarts at every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    frame_d = frame_q;
    rsh_d   = rsh_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.REQ_VALID && ready) begin
          wr_d    = bus.REQ_WRITE;
          frame_d = {bus.REQ_ADDR, bus.REQ_WDATA};
          state_d = S_STRB;
        end
      end
      S_STRB: begin
        cnt_d   = '0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        frame_d = frame_q << 1;
        if (cnt_q == A_LAST) begin
          cnt_d = '0;
          if (wr_q)             state_d = S_WDATA;
          else if (RD_TURN > 0) state_d = S_TURN;
          else                  state_d = S_RDATA;
        end
      end
      S_WDATA: begin
        frame_d = frame_q << 1;
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_TURN: begin
        if (cnt_q == T_LAST) begin
          cnt_d   = '0;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        rsh_d = DATA_WIDTH'({rsh_q, bus.DOUT});
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          rdata_d = rsh_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (cnt_q == G_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      rsh_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      rsh_q   <= rsh_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      init_q  <= 1'b1;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign bus.REQ_READY = ready;
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.WR_EN     = (state_q == S_STRB) &&  wr_q;
  assign bus.RD_EN     = (state_q == S_STRB) && !wr_q;
  assign bus.DIN       = ((state_q == S_ADDR) || (state_q == S_WDATA)) ? frame_q[FW-1] : 1'b0;
  assign bus.RSP_VALID = (state_q == S_DONE);
  assign bus.RSP_RDATA = rdata_q;

endmodule
